full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
- Ripple-carry full adder computing {carry, sum} = a + b + c.
- Combinational result is always available.
- A registered copy with a valid flag is provided for pipelined datapaths.
- Default WIDTH=1 gives the classic 1-bit full adder; wider instances serve as small adder slices in the arithmetic datapath.

Parameters:
- WIDTH, 1, operand width in bits (legal range 1..64).
- CNT_W, 16, width of the optional carry-event counter.

Ports:
- clk  input  1  rising-edge clock for the registered outputs.
- rst  input  1  asynchronous active-high reset.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- c  input  1  carry-in.
- in_vld  input  1  qualifies a/b/c for capture on the next rising clk edge.
- sum  output  WIDTH  combinational sum bits.
- carry  output  1  combinational carry-out.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  1  registered carry-out.
- out_vld  output  1  registered valid; high the cycle after an accepted in_vld.
- carry_cnt  output  CNT_W  carry-out event count (present only with FA_CARRY_CNT_EN).

Behaviour:
- Combinational path:
  - sum = (a + b + c) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - Built as a ripple chain of 1-bit cells: s_i = a_i ^ b_i ^ k_i; k_(i+1) = a_i&b_i | a_i&k_i | b_i&k_i; k_0 = c; carry = k_WIDTH.
  - Zero latency; no dependence on clk, rst or in_vld.
  - X/Z on any input propagates per standard gate semantics; no masking.
- Registered path:
  - On a rising clk edge with in_vld=1: sum_q<=sum, carry_q<=carry, out_vld<=1.
  - On a rising clk edge with in_vld=0: out_vld<=0; sum_q and carry_q hold their previous values.
  - Latency from input to registered output is exactly 1 cycle. There is no backpressure and every valid input is accepted.
- Reset:
  - rst=1 asynchronously forces sum_q=0, carry_q=0, out_vld=0 and carry_cnt=0, independent of clk.
  - While rst is asserted, the registers hold zero even if in_vld=1.
  - The first capture after reset occurs on the first rising edge at which rst is already low.
  - Reset mid-stream discards any captured data.
  - Combinational sum/carry remain live during reset.
- Boundaries:
  - All-ones a and b with c=1 gives sum = all-ones and carry=1.
  - All-zero inputs give sum=0 and carry=0.
  - Wrap-around beyond 2^WIDTH is reported only through carry.

Optional Feature:
- FA_CARRY_CNT_EN defined:
  - carry_cnt port exists.
  - carry_cnt increments by 1 on each rising clk edge where in_vld=1 and carry=1.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - It resets to 0 asynchronously with rst.
- FA_CARRY_CNT_EN undefined:
  - carry_cnt port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=1, exhaustive sweep of {a,b,c} = 0..7, 5 time units each -> (sum,carry) = (0,0),(1,0),(1,0),(0,1),(1,0),(0,1),(0,1),(1,1).
- WIDTH=1, a=1, b=1, c=1, in_vld=1 for one clk edge -> next cycle sum_q=1, carry_q=1, out_vld=1; following cycle with in_vld=0 -> out_vld=0, sum_q still 1.
- WIDTH=8, a=8'hFF, b=8'h00, c=1 -> sum=8'h00, carry=1; a=8'h7F, b=8'h01, c=0 -> sum=8'h80, carry=0.
- Assert rst asynchronously between clock edges while out_vld=1 and sum_q=1 -> sum_q, carry_q and out_vld drop to 0 immediately; combinational sum still tracks the inputs.
- FA_CARRY_CNT_EN defined, CNT_W=2, apply 5 valid cycles with carry=1 and 2 cycles with carry=0 -> carry_cnt saturates at 3; pulse rst -> carry_cnt=0.
- Random sweep, 1000 vectors, WIDTH=16 -> {carry,sum} equals a+b+c every vector; registered outputs match the previous cycle's combinational values whenever out_vld=1.

Source files
------------

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder (with leaf cell full_adder_cell)
// Description : Ripple-carry adder computing {carry, sum} = a + b + c, with a
//               registered copy of the result and a valid flag for use in
//               pipelined datapaths. WIDTH=1 is the classic 1-bit full adder.
//
// Parameters  : WIDTH  operand width in bits, legal range 1..64
//               CNT_W  width of the optional carry-event counter
//
// Ports       : clk        rising-edge clock for the registered outputs
//               rst        asynchronous active-high reset
//               a, b       addends, WIDTH bits
//               c          carry-in
//               in_vld     qualifies a/b/c for capture on the next clk edge
//               sum        combinational sum, WIDTH bits
//               carry      combinational carry-out
//               sum_q      registered sum
//               carry_q    registered carry-out
//               out_vld    high the cycle after an accepted in_vld
//               carry_cnt  saturating count of captured carry-outs
//                          (present only when FA_CARRY_CNT_EN is defined)
//
// Build macro : FA_CARRY_CNT_EN  adds the carry_cnt port and counter
//
// Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// One bit of the ripple chain. Written as plain gates so X/Z on any input
// propagates with ordinary gate semantics.
// ----------------------------------------------------------------------------
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    input  logic             in_vld,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
`ifdef FA_CARRY_CNT_EN
    output logic             out_vld,
    output logic [CNT_W-1:0] carry_cnt
`else
    output logic             out_vld
`endif
);

    // Reject out-of-range configurations at elaboration time.
    if (WIDTH < 1 || WIDTH > 64 || CNT_W < 1) begin : g_bad_params
        $error("full_adder: WIDTH must be 1..64 and CNT_W >= 1");
    end

    // ------------------------------------------------------------------------
    // Combinational ripple chain. w_k[i] is the carry into bit i; w_k[0] is
    // the external carry-in and w_k[WIDTH] is the carry-out.
    // ------------------------------------------------------------------------
    logic [WIDTH:0] w_k;

    assign w_k[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_k[i]),
            .s  (sum[i]),
            .co (w_k[i+1])
        );
    end

    assign carry = w_k[WIDTH];

    // ------------------------------------------------------------------------
    // Registered copy. Data registers only load on a valid input so that the
    // last accepted result stays visible while the stream is idle.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_sum_q;
    logic             r_carry_q;
    logic             r_out_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum_q   <= '0;
            r_carry_q <= 1'b0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= in_vld;
            if (in_vld) begin
                r_sum_q   <= sum;
                r_carry_q <= carry;
            end
        end
    end

    assign sum_q   = r_sum_q;
    assign carry_q = r_carry_q;
    assign out_vld = r_out_vld;

`ifdef FA_CARRY_CNT_EN
    // ------------------------------------------------------------------------
    // Carry-event counter: counts captured inputs that produced a carry-out,
    // sticking at its maximum rather than wrapping so an overflowing count is
    // never mistaken for a small one.
    // ------------------------------------------------------------------------
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_carry_cnt;
    logic             w_cnt_inc;

    assign w_cnt_inc = in_vld & carry & (r_carry_cnt != c_CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_carry_cnt <= r_carry_cnt + c_CNT_ONE;
        end
    end

    assign carry_cnt = r_carry_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_full_adder
// Description : Self-checking bench for full_adder. Drives WIDTH=1, 8 and 16
//               instances from a shared clock and reset, checks a truth-table
//               of vectors, hand-written register/reset sequences and a
//               randomized WIDTH=16 sweep against an arithmetic model.
//               The carry counter section is built when FA_CARRY_CNT_EN is
//               defined.
// Revision    : 1.0  initial release
// ============================================================================
module tb_full_adder;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    // WIDTH=1 instance (also carries the CNT_W=2 counter when enabled)
    logic       a1, b1, c1, v1;
    logic       s1, k1, sq1, kq1, ov1;
`ifdef FA_CARRY_CNT_EN
    logic [1:0] cnt1;
`endif

    // WIDTH=8 instance
    logic [7:0] a8, b8, s8, sq8;
    logic       c8, v8, k8, kq8, ov8;

    // WIDTH=16 instance
    logic [15:0] a16, b16, s16, sq16;
    logic        c16, v16, k16, kq16, ov16;

    full_adder #(.WIDTH(1), .CNT_W(2)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .in_vld    (v1),
        .sum       (s1),
        .carry     (k1),
        .sum_q     (sq1),
        .carry_q   (kq1),
`ifdef FA_CARRY_CNT_EN
        .out_vld   (ov1),
        .carry_cnt (cnt1)
`else
        .out_vld   (ov1)
`endif
    );

`ifdef FA_CARRY_CNT_EN
    logic [15:0] cnt8_unused, cnt16_unused;
`endif

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .a         (a8),
        .b         (b8),
        .c         (c8),
        .in_vld    (v8),
        .sum       (s8),
        .carry     (k8),
        .sum_q     (sq8),
        .carry_q   (kq8),
`ifdef FA_CARRY_CNT_EN
        .out_vld   (ov8),
        .carry_cnt (cnt8_unused)
`else
        .out_vld   (ov8)
`endif
    );

    full_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .a         (a16),
        .b         (b16),
        .c         (c16),
        .in_vld    (v16),
        .sum       (s16),
        .carry     (k16),
        .sum_q     (sq16),
        .carry_q   (kq16),
`ifdef FA_CARRY_CNT_EN
        .out_vld   (ov16),
        .carry_cnt (cnt16_unused)
`else
        .out_vld   (ov16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] abc;
        logic       s;
        logic       k;
    } vec1_t;

    vec1_t tbl [8];

    initial begin
        logic [16:0] e16;
        logic [15:0] m_sum;
        logic        m_carry;
        logic        m_vld;
        int          m_cnt;

        n_checks = 0;
        n_fail   = 0;

        // Truth table of the 1-bit full adder, {a,b,c} = 0..7
        tbl[0] = '{3'd0, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 1'b1, 1'b0};
        tbl[3] = '{3'd3, 1'b0, 1'b1};
        tbl[4] = '{3'd4, 1'b1, 1'b0};
        tbl[5] = '{3'd5, 1'b0, 1'b1};
        tbl[6] = '{3'd6, 1'b0, 1'b1};
        tbl[7] = '{3'd7, 1'b1, 1'b1};

        rst = 1'b1;
        a1 = 0; b1 = 0; c1 = 0; v1 = 0;
        a8 = 0; b8 = 0; c8 = 0; v8 = 0;
        a16 = 0; b16 = 0; c16 = 0; v16 = 0;

        // Reset state, before any clock edge
        #2;
        chk("rst_sum_q1",   64'(sq1),  64'(0));
        chk("rst_carry_q1", 64'(kq1),  64'(0));
        chk("rst_out_vld1", 64'(ov1),  64'(0));
        chk("rst_sum_q16",  64'(sq16), 64'(0));
        chk("rst_out_vld16",64'(ov16), 64'(0));
        // Combinational path is live during reset
        a1 = 1'b1;
        #1;
        chk("rst_comb_sum1", 64'(s1), 64'(1));
        a1 = 1'b0;

        @(negedge clk);
        rst = 1'b0;

        // Exhaustive 1-bit truth table
        for (int i = 0; i < 8; i++) begin
            {a1, b1, c1} = tbl[i].abc;
            #5;
            chk($sformatf("tt_sum[%0d]", i),   64'(s1), 64'(tbl[i].s));
            chk($sformatf("tt_carry[%0d]", i), 64'(k1), 64'(tbl[i].k));
        end

        // WIDTH=8 boundaries
        a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; #1;
        chk("w8_ff_sum",   64'(s8), 64'h00);
        chk("w8_ff_carry", 64'(k8), 64'(1));
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; #1;
        chk("w8_7f_sum",   64'(s8), 64'h80);
        chk("w8_7f_carry", 64'(k8), 64'(0));
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; #1;
        chk("w8_ones_sum",   64'(s8), 64'hFF);
        chk("w8_ones_carry", 64'(k8), 64'(1));
        a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; #1;
        chk("w8_zero_sum",   64'(s8), 64'h00);
        chk("w8_zero_carry", 64'(k8), 64'(0));

        // Registered capture then idle hold
        @(negedge clk);
        a1 = 1; b1 = 1; c1 = 1; v1 = 1;
        @(posedge clk); #1;
        chk("reg_sum_q",   64'(sq1), 64'(1));
        chk("reg_carry_q", 64'(kq1), 64'(1));
        chk("reg_out_vld", 64'(ov1), 64'(1));
        @(negedge clk);
        a1 = 0; b1 = 0; c1 = 0; v1 = 0;
        @(posedge clk); #1;
        chk("idle_out_vld", 64'(ov1), 64'(0));
        chk("idle_sum_q",   64'(sq1), 64'(1));
        chk("idle_carry_q", 64'(kq1), 64'(1));

        // Asynchronous reset mid-stream
        @(negedge clk);
        a1 = 1; b1 = 0; c1 = 0; v1 = 1;
        @(posedge clk); #1;
        chk("pre_arst_sum_q",   64'(sq1), 64'(1));
        chk("pre_arst_out_vld", 64'(ov1), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        chk("arst_sum_q",   64'(sq1), 64'(0));
        chk("arst_carry_q", 64'(kq1), 64'(0));
        chk("arst_out_vld", 64'(ov1), 64'(0));
        a1 = 0; b1 = 1; c1 = 1;
        #1;
        chk("arst_comb_sum",   64'(s1), 64'(0));
        chk("arst_comb_carry", 64'(k1), 64'(1));
        // Valid input while reset held must not load
        a1 = 1; b1 = 1; c1 = 1; v1 = 1;
        @(posedge clk); #1;
        chk("rst_hold_sum_q",   64'(sq1), 64'(0));
        chk("rst_hold_out_vld", 64'(ov1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_sum_q",   64'(sq1), 64'(1));
        chk("post_rst_carry_q", 64'(kq1), 64'(1));
        chk("post_rst_out_vld", 64'(ov1), 64'(1));
        @(negedge clk);
        v1 = 0;

`ifdef FA_CARRY_CNT_EN
        // Saturating carry counter, CNT_W=2
        rst = 1'b1;
        #1;
        chk("cnt_rst0", 64'(cnt1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        m_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a1 = (i < 5); b1 = (i < 5); c1 = 0; v1 = 1;
            @(posedge clk); #1;
            if (i < 5) m_cnt = (m_cnt + 1 > 3) ? 3 : m_cnt + 1;
            chk($sformatf("cnt_step[%0d]", i), 64'(cnt1), 64'(m_cnt));
        end
        chk("cnt_saturated", 64'(cnt1), 64'(3));
        @(negedge clk);
        v1 = 0;
        rst = 1'b1;
        #1;
        chk("cnt_rst1", 64'(cnt1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
`endif

        // Randomized WIDTH=16 sweep against arithmetic model
        m_sum   = '0;
        m_carry = 1'b0;
        m_vld   = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom_range(0, 1));
            v16 = 1'($urandom_range(0, 1));
            if (i % 97 == 0) begin
                a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
            end
            #1;
            e16 = 17'(a16) + 17'(b16) + 17'(c16);
            chk("rnd_comb", 64'({k16, s16}), 64'(e16));
            @(posedge clk); #1;
            if (v16) begin
                m_sum   = e16[15:0];
                m_carry = e16[16];
            end
            m_vld = v16;
            chk("rnd_out_vld", 64'(ov16), 64'(m_vld));
            chk("rnd_sum_q",   64'(sq16), 64'(m_sum));
            chk("rnd_carry_q", 64'(kq16), 64'(m_carry));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
